transpose_buf_8x8: RTL
======================

Name: transpose_buf_8x8

Overview:
- Ping-pong 8x8 transpose buffer that sits directly downstream of the row-pass forward binDCT.
- Accepts one 8-sample DCT row per handshake and stores 8 rows as one block.
- Emits the block column by column to the column-pass DCT.
- Rescales each sample: arithmetic right shift, then saturation to the column-pass input width.
- Two banks, so the row pass can fill one bank while the other drains.

Parameters:
- IN_WIDTH, 20: signed width of each incoming row sample (row-pass output width).
- OUT_WIDTH, 12: signed width of each outgoing column sample.
- SHIFT, 6: arithmetic right shift applied before saturation; drops the row-pass fraction bits.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- row_in  in  IN_WIDTH x [7:0]  signed row samples; index i is frequency i of the current row.
- in_valid  in  1  row_in is valid; held until accepted.
- in_ready  out  1  buffer can accept a row this cycle.
- col_out  out  OUT_WIDTH x [7:0]  signed column samples; index r is row r of the current column.
- out_valid  out  1  col_out is valid.
- out_ready  in  1  downstream accepts col_out this cycle.
- out_first  out  1  current column is column 0 of a block; qualified by out_valid.
- out_last  out  1  current column is column 7 of a block; qualified by out_valid.

Behaviour:
- Storage: two banks, each 8x8 of OUT_WIDTH bits.
  - Each sample is scaled on write: s = row_in[i] >>> SHIFT.
  - s is then clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - The shift truncates toward minus infinity; there is no rounding.
- Write side:
  - wr_bank (1 bit) selects the bank; wr_row (3 bits) selects the row.
  - A write happens on a rising edge where in_valid && in_ready. Sample i goes to bank[wr_bank][wr_row][i], and wr_row increments.
  - On the write with wr_row==7: set full[wr_bank], toggle wr_bank, wrap wr_row to 0.
  - in_ready = !full[wr_bank], combinational from registers only.
- Read side:
  - rd_bank (1 bit) selects the bank; rd_col (3 bits) selects the column.
  - out_valid = full[rd_bank].
  - col_out[r] = bank[rd_bank][r][rd_col] when out_valid; all zeros otherwise.
  - out_first = out_valid && rd_col==0; out_last = out_valid && rd_col==7.
  - A transfer happens on a rising edge where out_valid && out_ready, and rd_col increments.
  - On the transfer with rd_col==7: clear full[rd_bank], toggle rd_bank, wrap rd_col to 0.
- Holding: while out_valid && !out_ready, col_out, out_first and out_last remain stable. A full bank is never written.
- Latency: the 8th row is accepted at edge N; out_valid is high from edge N (same cycle as the full flag set). Column 0 is visible in the cycle after edge N.
- Throughput: one row per cycle in, one column per cycle out. A continuous stream sustains 64 samples per 8 cycles with no bubbles once both sides are ready.
- Simultaneous events:
  - Write of the last row into bank A and read of the last column of bank B on the same edge: both take effect. full[A] sets, full[B] clears, and both pointers toggle.
  - Set and clear never target the same bank on the same edge.
- Both banks full: in_ready=0. in_valid is held off with no data loss; the upstream DCT stays in its SEND state.
- Both banks empty: out_valid=0 and col_out=0. out_ready is ignored.
- Reset (asserted at any time, including mid-block): asynchronously clears wr_bank, wr_row, rd_bank, rd_col and full[1:0]. Any partial block is discarded.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_first=0, out_last=0, col_out=0.
  - Bank contents need not be reset.
- in_valid is ignored while in_ready=0. Data is captured only on the handshake edge.

Test Plan:
- Single block: write rows r=0..7 with row_in[i]=(8r+i)*64, out_ready=1. Required:
  - Column 0 = {0,8,16,24,32,40,48,56}.
  - Column 7 = {7,15,...,63}.
  - out_first only on column 0; out_last only on column 7.
  - out_valid asserts the cycle after the 8th row.
- Backpressure: fill both banks with out_ready=0. Required:
  - in_ready drops after 16 rows, and the 17th row is held, not lost.
  - Raise out_ready: 16 columns emerge in order, bank A then bank B.
  - in_ready returns after column 7 of bank A is taken.
- Stall mid-column: drop out_ready for 5 cycles during column 3. Required: col_out, out_first and out_last stay constant; column 4 follows after the stall.
- Saturation/shift, per sample:
  - 524287 -> 2047.
  - -524288 -> -2048.
  - -65 -> -2.
  - 127 -> 1.
  - 64 -> 1.
- Overlap: stream 3 blocks continuously with both sides always ready. Required: no bubble in in_ready after the first block; the last-row write and last-column read coincide on one edge with correct data.
- Reset mid-block: assert rst low after 5 rows of block 0. Required:
  - Immediately: in_ready=1, out_valid=0, col_out=0.
  - After release, a fresh 8-row block transposes correctly, with no residue from the partial block.

Source files
------------

// File: rtl/transpose_buf_8x8.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass binDCT.
// Rows are scaled/saturated on write; columns are read out combinationally from the full bank.
module transpose_buf_8x8 #(
  parameter int IN_WIDTH  = 20,
  parameter int OUT_WIDTH = 12,
  parameter int SHIFT     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  row_in    [0:7],
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] col_out   [0:7],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_first,
  output logic                        out_last
);

  localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_LO = ~SAT_HI;

  // Floor-shift (no rounding) followed by a clamp to the column-pass input range.
  function automatic logic signed [OUT_WIDTH-1:0] scale_sat(
    input logic signed [IN_WIDTH-1:0] x
  );
    logic signed [IN_WIDTH-1:0] s;
    s = x >>> SHIFT;
    if (s > SAT_HI) begin
      return SAT_HI[OUT_WIDTH-1:0];
    end else if (s < SAT_LO) begin
      return SAT_LO[OUT_WIDTH-1:0];
    end
    return s[OUT_WIDTH-1:0];
  endfunction

  logic                        wr_bank_q, wr_bank_d;
  logic [2:0]                  wr_row_q,  wr_row_d;
  logic                        rd_bank_q, rd_bank_d;
  logic [2:0]                  rd_col_q,  rd_col_d;
  logic [1:0]                  full_q,    full_d;
  logic signed [OUT_WIDTH-1:0] mem_q [0:1][0:7][0:7];

  logic wr_fire;
  logic rd_fire;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_first = out_valid && (rd_col_q == 3'd0);
  assign out_last  = out_valid && (rd_col_q == 3'd7);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  // Set and clear can land on the same edge but always on different banks.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_row_d  = wr_row_q;
    rd_bank_d = rd_bank_q;
    rd_col_d  = rd_col_q;
    full_d    = full_q;
    if (wr_fire) begin
      wr_row_d = wr_row_q + 3'd1;
      if (wr_row_q == 3'd7) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_fire) begin
      rd_col_d = rd_col_q + 3'd1;
      if (rd_col_q == 3'd7) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q <= 1'b0;
      wr_row_q  <= 3'd0;
      rd_bank_q <= 1'b0;
      rd_col_q  <= 3'd0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      wr_row_q  <= wr_row_d;
      rd_bank_q <= rd_bank_d;
      rd_col_q  <= rd_col_d;
      full_q    <= full_d;
    end
  end

  // Sample storage carries no reset; the full flags alone decide what is live.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[wr_bank_q][wr_row_q][i] <= scale_sat(row_in[i]);
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      col_out[r] = '0;
      if (out_valid) begin
        col_out[r] = mem_q[rd_bank_q][r][rd_col_q];
      end
    end
  end

endmodule
